// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// constants and ALU control codes.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpJ     = 6'h02;

    localparam logic [5:0] FunctAdd = 6'h20;
    localparam logic [5:0] FunctSub = 6'h22;
    localparam logic [5:0] FunctAnd = 6'h24;
    localparam logic [5:0] FunctOr  = 6'h25;
    localparam logic [5:0] FunctSlt = 6'h2A;

    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluSlt = 4'b0111;

    localparam logic [1:0] PcSrcPlus4  = 2'b00;
    localparam logic [1:0] PcSrcBranch = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decode: maps opcode/funct to an ALU operation and flags
// encodings the controller does not support.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       legal_o
);

    always_comb begin
        alu_ctrl_o = AluAnd;
        legal_o    = 1'b0;
        case (opcode_i)
            OpRtype: begin
                case (funct_i)
                    FunctAdd: begin alu_ctrl_o = AluAdd; legal_o = 1'b1; end
                    FunctSub: begin alu_ctrl_o = AluSub; legal_o = 1'b1; end
                    FunctAnd: begin alu_ctrl_o = AluAnd; legal_o = 1'b1; end
                    FunctOr:  begin alu_ctrl_o = AluOr;  legal_o = 1'b1; end
                    FunctSlt: begin alu_ctrl_o = AluSlt; legal_o = 1'b1; end
                    default:  ;
                endcase
            end
            OpLw, OpSw, OpAddi: begin alu_ctrl_o = AluAdd; legal_o = 1'b1; end
            OpBeq:              begin alu_ctrl_o = AluSub; legal_o = 1'b1; end
            // Jumps never use the ALU.
            OpJ:                legal_o = 1'b1;
            default:            ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller: IDLE/FETCH/DECODE/EXEC/MEM/WB FSM driving datapath
// strobes, plus a wrapping retired-instruction counter.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        alu_src,
    output logic [3:0]  alu_ctrl,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_to_reg,
    output logic        done,
    output logic        illegal,
    output logic [15:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [15:0] retired_q, retired_d;

    logic [5:0] opcode, funct;
    logic [3:0] dec_alu_ctrl;
    logic       legal;
    logic       is_r, is_lw, is_sw, is_beq, is_addi, is_j, uses_imm;
    logic       unused_ir;

    assign opcode    = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign unused_ir = ^ir_q[25:6];

    assign is_r     = (opcode == OpRtype);
    assign is_lw    = (opcode == OpLw);
    assign is_sw    = (opcode == OpSw);
    assign is_beq   = (opcode == OpBeq);
    assign is_addi  = (opcode == OpAddi);
    assign is_j     = (opcode == OpJ);
    assign uses_imm = is_addi | is_lw | is_sw;

    alu_decoder u_alu_decoder (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .alu_ctrl_o (dec_alu_ctrl),
        .legal_o    (legal)
    );

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    ir_d    = instr;
                    state_d = StFetch;
                end
            end
            StFetch:  state_d = StDecode;
            StDecode: state_d = (!legal || is_j) ? StIdle : StExec;
            StExec: begin
                if (is_lw || is_sw)       state_d = StMem;
                else if (is_r || is_addi) state_d = StWb;
                else                      state_d = StIdle;
            end
            StMem: begin
                if (mem_ack) state_d = is_lw ? StWb : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PcSrcPlus4;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = AluAnd;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StIdle: ready = 1'b1;
            StFetch: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
            end
            StDecode: begin
                alu_ctrl = dec_alu_ctrl;
                if (!legal) begin
                    illegal = 1'b1;
                end else if (is_j) begin
                    pc_we  = 1'b1;
                    pc_src = PcSrcJump;
                    done   = 1'b1;
                end
            end
            StExec: begin
                alu_ctrl = dec_alu_ctrl;
                alu_src  = uses_imm;
                if (is_beq) begin
                    pc_we  = zero;
                    pc_src = PcSrcBranch;
                    done   = 1'b1;
                end
            end
            StMem: begin
                alu_ctrl = dec_alu_ctrl;
                mem_rd   = is_lw;
                mem_wr   = is_sw;
                // A store retires in the cycle its acknowledge arrives.
                done     = is_sw & mem_ack;
            end
            StWb: begin
                alu_ctrl   = dec_alu_ctrl;
                alu_src    = uses_imm;
                reg_we     = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    assign retired_d = done ? retired_q + 16'd1 : retired_q;
    assign retired   = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset: the clock is CLK; the reset is rst, asynchronous and active-low.
REQ-002 Port list SHALL be (name  direction  width  meaning):
- CLK  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  request to execute one instruction
- instr  in  32  instruction word, sampled when start is accepted
- zero  in  1  ALU zero flag from execute datapath
- mem_ack  in  1  data-memory completion handshake
- ready  out  1  FSM in IDLE, start will be accepted
- ir_we  out  1  instruction-register write enable
- pc_we  out  1  PC write enable
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- reg_we  out  1  register-file write enable (busW commit)
- reg_dst  out  1  1 = rd, 0 = rt destination
- alu_src  out  1  1 = sign-extended immediate, 0 = busB
- alu_ctrl  out  4  ALU operation code
- mem_rd, mem_wr  out  1 each  data-memory strobes
- mem_to_reg  out  1  1 = memory data onto busW
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse, unsupported encoding
- retired  out  16  retired-instruction counter

Function
REQ-003 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB; all outputs except retired are Moore functions of state and the internal IR.
REQ-004 IDLE: ready=1; on start=1 latch instr into IR and go to FETCH; start outside IDLE is ignored.
REQ-005 FETCH: ir_we=1, pc_we=1, pc_src=00 for exactly one cycle, then DECODE.
REQ-006 Supported encodings: R-type (opcode 0x00) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; opcodes 0x23 lw, 0x2B sw, 0x04 beq, 0x08 addi, 0x02 j.
REQ-007 alu_ctrl SHALL be 0010 add/addi/lw/sw, 0110 sub/beq, 0000 and, 0001 or, 0111 slt; 0000 in IDLE and FETCH.
REQ-008 Sequences: R-type and addi FETCH-DECODE-EXEC-WB; lw FETCH-DECODE-EXEC-MEM-WB; sw FETCH-DECODE-EXEC-MEM; beq FETCH-DECODE-EXEC; j FETCH-DECODE; every sequence then returns to IDLE.
REQ-009 j in DECODE: pc_we=1, pc_src=10. beq in EXEC: pc_we=zero, pc_src=01.
REQ-010 MEM: mem_rd (lw) or mem_wr (sw) held high every cycle until mem_ack=1; it leaves MEM on the edge where mem_ack=1, with no timeout.
REQ-011 WB: reg_we=1; reg_dst=1 and mem_to_reg=0 for R-type; reg_dst=0 for lw and addi; mem_to_reg=1 for lw only. alu_src=1 for addi/lw/sw in EXEC and WB.
REQ-012 done=1 in the final state of each sequence (one cycle); retired SHALL increment on that same edge and wrap 0xFFFF to 0x0000.
REQ-013 Unsupported opcode or funct: DECODE asserts illegal=1 for one cycle, then IDLE; no reg_we, pc_we, mem strobe, done or retired change.
REQ-014 Latency from start accepted to done: R-type/addi 4 cycles, lw 5+N cycles and sw 4+N cycles (N = mem_ack wait cycles), beq 3 cycles, j 2 cycles.

Reset
REQ-015 rst=0 SHALL force IDLE, IR=0 and retired=0, and SHALL drive every output to 0 except ready=1, asynchronously and including mid-sequence.
REQ-016 After rst deasserts, the first accepted start is evaluated on the next CLK edge; an aborted instruction is not retired.

Structure
REQ-017 Package mips_ctrl_pkg SHALL hold the state encoding, opcode/funct constants and alu_ctrl codes.
REQ-018 ALU-control decoding (opcode, funct to alu_ctrl, legal flag) SHALL be a combinational sub-module alu_decoder; the FSM and the counter are in multicycle_ctrl.

Verification
REQ-019 start with instr=0x00000820 (add r1,r0,r0) -> FETCH, DECODE, EXEC, WB; reg_we=1, reg_dst=1 in WB; done on cycle 4; retired 0 to 1.
REQ-020 lw 0x8C220004 with mem_ack low for 3 cycles -> mem_rd high 4 cycles, then WB with mem_to_reg=1; done on cycle 8.
REQ-021 beq 0x10000002 with zero=1 -> pc_we=1, pc_src=01 in EXEC; with zero=0 -> pc_we=0; done on cycle 3 in both cases.
REQ-022 instr=0xFC000000 -> illegal pulse in DECODE, no done, retired unchanged, ready on the following cycle.
REQ-023 rst low during MEM of sw -> mem_wr drops immediately, ready=1, retired=0; start held high during EXEC -> ignored.
REQ-024 Preload 0xFFFF retired instructions, then one j 0x08000000 -> retired wraps to 0x0000 and done occurs on cycle 2.
